lsu_mem_port: RTL and testbench

Load/store initiator between the RV32I core datapath and the byte-banked word RAM (32-bit word-addressed, 4 byte lanes, 1-cycle registered read).
- Accepts one load or store at a time from the core.
- Converts byte addresses to word addresses and generates byte enables and lane-replicated write data.
- Aligns and sign/zero-extends load data, then returns a response under a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 61 ++++++
 rtl/lsu_load_align.sv | 31 +++
 rtl/lsu_mem_port.sv | 182 ++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory port: FSM states,
// RV32I funct3 encodings, legality/alignment checks and store lane helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants exist only for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << off;
      F3_H:    be = 4'b0011 << {off[1], 1'b0};
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3)
      F3_B:    d = {4{wd[7:0]}};
      F3_H:    d = {2{wd[15:0]}};
      F3_W:    d = wd;
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of a RAM
// word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] byte_sh_s;
  logic [31:0] half_sh_s;

  assign byte_sh_s = word >> {addr_lo, 3'b000};
  assign half_sh_s = word >> {addr_lo[1], 4'b0000};

  // Extend the selected lane; illegal encodings produce zero.
  always_comb begin
    data = 32'h0000_0000;
    case (funct3)
      F3_B:    data = {{24{byte_sh_s[7]}}, byte_sh_s[7:0]};
      F3_H:    data = {{16{half_sh_s[15]}}, half_sh_s[15:0]};
      F3_W:    data = word;
      F3_BU:   data = {24'h00_0000, byte_sh_s[7:0]};
      F3_HU:   data = {16'h0000, half_sh_s[15:0]};
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator between the RV32I core and a byte-banked word RAM.
// Build option LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_funct3,
  input  logic [ADDR_WIDTH:0]   i_req_addr,
  input  logic [DATA_WIDTH:0]   i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH:0]   o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_mem_read_req,
  output logic [ADDR_WIDTH:0]   o_mem_read_addr,
  input  logic [DATA_WIDTH:0]   i_mem_read_data,
  output logic                  o_mem_write_enable,
  output logic [3:0]            o_mem_byte_enable,
  output logic [ADDR_WIDTH:0]   o_mem_write_addr,
  output logic [DATA_WIDTH:0]   o_mem_write_data
);

  lsu_state_t state_r, next_state_s;

  logic                we_r;
  logic [2:0]          funct3_r;
  logic [ADDR_WIDTH:0] addr_r;
  logic [DATA_WIDTH:0] wdata_r;

  logic                accept_s, req_ok_s;
  logic                cur_we_s;
  logic [2:0]          cur_f3_s;
  logic [ADDR_WIDTH:0] cur_addr_s, word_addr_s;
  logic [DATA_WIDTH:0] cur_wdata_s, align_s;

  logic                ready_nxt_s, rsp_valid_nxt_s, err_nxt_s, rd_nxt_s, wr_nxt_s;
  logic [DATA_WIDTH:0] rdata_nxt_s, wdata_nxt_s;
  logic [ADDR_WIDTH:0] raddr_nxt_s, waddr_nxt_s;
  logic [3:0]          be_nxt_s;

  // Outputs are decoded from the incoming request while it is being accepted.
  assign accept_s    = (state_r == IDLE) && i_req_valid;
  assign cur_we_s    = accept_s ? i_req_we     : we_r;
  assign cur_f3_s    = accept_s ? i_req_funct3 : funct3_r;
  assign cur_addr_s  = accept_s ? i_req_addr   : addr_r;
  assign cur_wdata_s = accept_s ? i_req_wdata  : wdata_r;
  assign word_addr_s = {2'b00, cur_addr_s[ADDR_WIDTH:2]};

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_ok_s = f3_legal(cur_we_s, cur_f3_s) && !f3_misaligned(cur_f3_s, cur_addr_s[1:0]);
`else
  assign req_ok_s = f3_legal(cur_we_s, cur_f3_s);
`endif

  lsu_load_align u_align (
    .word    (i_mem_read_data),
    .addr_lo (addr_r[1:0]),
    .funct3  (funct3_r),
    .data    (align_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else if (clk_en) begin
      state_r <= next_state_s;
    end
  end

  // Request capture on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r     <= 1'b0;
      funct3_r <= 3'b000;
      addr_r   <= '0;
      wdata_r  <= '0;
    end else if (clk_en && accept_s) begin
      we_r     <= i_req_we;
      funct3_r <= i_req_funct3;
      addr_r   <= i_req_addr;
      wdata_r  <= i_req_wdata;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_req_valid) begin
          next_state_s = req_ok_s ? ISSUE : RESP;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE:   next_state_s = we_r ? RESP : WAIT;
      WAIT:    next_state_s = RESP;
      RESP: begin
        if (i_rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode: values the output registers take on the next enabled edge.
  always_comb begin
    ready_nxt_s     = (next_state_s == IDLE);
    rsp_valid_nxt_s = (next_state_s == RESP);
    rd_nxt_s        = (next_state_s == ISSUE) && !cur_we_s;
    wr_nxt_s        = (next_state_s == ISSUE) && cur_we_s;
    raddr_nxt_s     = rd_nxt_s ? word_addr_s : '0;
    waddr_nxt_s     = wr_nxt_s ? word_addr_s : '0;
    be_nxt_s        = wr_nxt_s ? store_be(cur_f3_s, cur_addr_s[1:0]) : 4'b0000;
    wdata_nxt_s     = wr_nxt_s ? store_data(cur_f3_s, cur_wdata_s) : '0;
    rdata_nxt_s     = '0;
    err_nxt_s       = 1'b0;
    if (next_state_s == RESP) begin
      case (state_r)
        IDLE: begin
          rdata_nxt_s = '0;
          err_nxt_s   = 1'b1;
        end
        WAIT: begin
          rdata_nxt_s = align_s;
          err_nxt_s   = 1'b0;
        end
        RESP: begin
          rdata_nxt_s = o_rsp_rdata;
          err_nxt_s   = o_rsp_err;
        end
        default: begin
          rdata_nxt_s = '0;
          err_nxt_s   = 1'b0;
        end
      endcase
    end else begin
      rdata_nxt_s = '0;
      err_nxt_s   = 1'b0;
    end
  end

  // Output registers; ready comes out of reset high since the FSM starts idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_req_ready        <= 1'b1;
      o_rsp_valid        <= 1'b0;
      o_rsp_rdata        <= '0;
      o_rsp_err          <= 1'b0;
      o_mem_read_req     <= 1'b0;
      o_mem_read_addr    <= '0;
      o_mem_write_enable <= 1'b0;
      o_mem_byte_enable  <= 4'b0000;
      o_mem_write_addr   <= '0;
      o_mem_write_data   <= '0;
    end else if (clk_en) begin
      o_req_ready        <= ready_nxt_s;
      o_rsp_valid        <= rsp_valid_nxt_s;
      o_rsp_rdata        <= rdata_nxt_s;
      o_rsp_err          <= err_nxt_s;
      o_mem_read_req     <= rd_nxt_s;
      o_mem_read_addr    <= raddr_nxt_s;
      o_mem_write_enable <= wr_nxt_s;
      o_mem_byte_enable  <= be_nxt_s;
      o_mem_write_addr   <= waddr_nxt_s;
      o_mem_write_data   <= wdata_nxt_s;
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed self-checking bench for lsu_mem_port with a byte-banked RAM model.
// Honours LSU_MISALIGN_TRAP_EN for the misaligned-word case.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        ce_tog = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_f3 = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_rd, mem_we;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [3:0]  mem_be;

  logic [31:0] ram [0:63];
  logic [31:0] last_waddr = 32'h0, last_wdata = 32'h0, last_raddr = 32'h0;
  logic [3:0]  last_be = 4'h0;
  int          n_strobe = 0;
  int          n_chk = 0, n_pass = 0;

  lsu_mem_port dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err), .o_mem_read_req(mem_rd), .o_mem_read_addr(mem_raddr),
    .i_mem_read_data(mem_rdata), .o_mem_write_enable(mem_we),
    .o_mem_byte_enable(mem_be), .o_mem_write_addr(mem_waddr),
    .o_mem_write_data(mem_wdata)
  );

  always #5 clk = ~clk;

  // Clock enable: steady high, or alternating every cycle.
  initial forever begin
    @(negedge clk);
    if (ce_tog) clk_en = ~clk_en;
    else        clk_en = 1'b1;
  end

  // RAM model: byte-lane writes, one-enabled-edge registered read.
  initial for (int i = 0; i < 64; i++) ram[i] = 32'h0;
  always @(posedge clk) begin
    if (clk_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_waddr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        last_waddr <= mem_waddr;
        last_wdata <= mem_wdata;
        last_be    <= mem_be;
      end
      if (mem_rd) begin
        mem_rdata  <= ram[mem_raddr[5:0]];
        last_raddr <= mem_raddr;
      end
      if (mem_we || mem_rd) n_strobe <= n_strobe + 1;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic en_edge();
    do @(posedge clk); while (!clk_en);
  endtask

  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input int exp_lat, input int hold);
    int lat;
    int s0;
    chk_eq({tag, ".ready"}, {31'h0, req_ready}, 32'd1);
    s0 = n_strobe;
    req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    en_edge(); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      en_edge(); #1;
      lat++;
    end
    chk_eq({tag, ".lat"}, lat, exp_lat);
    chk_eq({tag, ".rdata"}, rsp_rdata, exp_rd);
    chk_eq({tag, ".err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    for (int i = 0; i < hold; i++) begin
      en_edge(); #1;
      chk_eq({tag, ".hold_v"}, {31'h0, rsp_valid}, 32'd1);
      chk_eq({tag, ".hold_d"}, rsp_rdata, exp_rd);
    end
    rsp_ready = 1'b1;
    en_edge(); #1;
    rsp_ready = 1'b0;
    chk_eq({tag, ".done_v"}, {31'h0, rsp_valid}, 32'd0);
    chk_eq({tag, ".strobes"}, n_strobe - s0, exp_err ? 32'd0 : 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst.ready", {31'h0, req_ready}, 32'd1);
    chk_eq("rst.rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk_eq("rst.strobe", {30'h0, mem_we, mem_rd}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Reset in the middle of a load waiting on RAM data.
    req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
    en_edge(); #1; req_valid = 1'b0;
    en_edge(); #2;
    rst_n = 1'b0; #1;
    chk_eq("arst.ready", {31'h0, req_ready}, 32'd1);
    chk_eq("arst.rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk_eq("arst.read_req", {31'h0, mem_rd}, 32'd0);
    chk_eq("arst.read_addr", mem_raddr, 32'd0);
    chk_eq("arst.rdata", rsp_rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    txn("lw_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0, 3, 0);

    txn("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0);
    chk_eq("sw10.waddr", last_waddr, 32'd4);
    chk_eq("sw10.be", {28'h0, last_be}, 32'hF);
    chk_eq("sw10.wdata", last_wdata, 32'hDEADBEEF);
    chk_eq("idle.wdata", mem_wdata, 32'h0);
    txn("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
    chk_eq("lw10.raddr", last_raddr, 32'd4);

    txn("sb13", 1'b1, 3'b000, 32'h13, 32'h80, 32'h0, 1'b0, 2, 0);
    chk_eq("sb13.be", {28'h0, last_be}, 32'h8);
    chk_eq("sb13.wdata", last_wdata, 32'h80808080);
    txn("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 3, 0);
    txn("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 3, 0);

    txn("sh22", 1'b1, 3'b001, 32'h22, 32'h8001, 32'h0, 1'b0, 2, 0);
    chk_eq("sh22.be", {28'h0, last_be}, 32'hC);
    chk_eq("sh22.waddr", last_waddr, 32'd8);
    txn("lh22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 3, 0);
    txn("lhu22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0, 3, 0);

    // Alternating clock enable with a slow consumer.
    ce_tog = 1'b1;
    txn("lw_ce", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 3, 5);
    ce_tog = 1'b0;
    @(negedge clk);

    txn("ill_ld", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
    txn("ill_sbu", 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    txn("lw11", 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0);
`else
    txn("lw11", 1'b0, 3'b010, 32'h11, 32'h0, 32'h80ADBEEF, 1'b0, 3, 0);
`endif
    txn("back2back", 1'b0, 3'b100, 32'h10, 32'h0, 32'h000000EF, 1'b0, 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
